// File: rtl/demorgan_pkg.sv
// Shared encodings and limits for the De Morgan NAND-stage pattern checker.
// Latency: n/a (types only). Backpressure: n/a.
package demorgan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int SETTLE_MAX = 15;
  localparam int PASSES_MAX = 15;
  localparam int CNT_W      = $clog2(SETTLE_MAX + 1);
  localparam int SWEEP_W    = $clog2(PASSES_MAX + 1);
  localparam int ERR_W      = 4;
  localparam logic [ERR_W-1:0] ERR_MAX = 4'd15;

  // NAND written in its De Morgan form so the checker states the identity it tests.
  function automatic logic nand_expected(input logic [1:0] v);
    return ~v[1] | ~v[0];
  endfunction

endpackage

// File: rtl/demorgan_pattern_checker_if.sv
// Run-control, result and NAND-stage operand bundle for the pattern checker.
// Latency: n/a (wires only). Backpressure: none, start is level-sampled.
interface demorgan_pattern_checker_if;
  import demorgan_pkg::*;

  logic             start;
  logic             dut_c;
  logic             dut_a;
  logic             dut_b;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic             fail_valid;
  logic [1:0]       first_fail_vec;

  modport master (
    output start, dut_c,
    input  dut_a, dut_b, busy, done, pass, err_count, fail_valid, first_fail_vec
  );

  modport slave (
    input  start, dut_c,
    output dut_a, dut_b, busy, done, pass, err_count, fail_valid, first_fail_vec
  );

endinterface

// File: rtl/demorgan_settle_timer.sv
// Settle countdown: load a cycle count, expired flags the last waiting cycle.
// Latency: expired is a decode of the registered count. Backpressure: none.
module demorgan_settle_timer
  import demorgan_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] count_in,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= count_in;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // The count holds 1 on the final wait cycle, so the FSM leaves WAIT on that edge.
  assign expired = (cnt <= CNT_W'(1));

endmodule

// File: rtl/demorgan_pattern_checker.sv
// Sweeps {a,b} through 00..11 into a NAND stage and scores dut_c against ~a|~b.
// Latency: 4*PASSES*(SETTLE_CYCLES+2) cycles start-to-done. Backpressure: start ignored while busy.
module demorgan_pattern_checker
  import demorgan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  demorgan_pattern_checker_if.slave  bus
);

  localparam logic [CNT_W-1:0]   SETTLE_LD  = CNT_W'(SETTLE_CYCLES);
  localparam logic [SWEEP_W-1:0] LAST_SWEEP = SWEEP_W'(PASSES - 1);

  state_t             state;
  logic [1:0]         vec;
  logic [SWEEP_W-1:0] sweep;
  logic               dut_a_q;
  logic               dut_b_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic [ERR_W-1:0]   err_q;
  logic               fv_q;
  logic [1:0]         ffv_q;

  logic               timer_load;
  logic               timer_expired;
  logic               mismatch;
  logic [ERR_W-1:0]   err_nxt;

  assign timer_load = (state == ST_DRIVE);

  demorgan_settle_timer u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .count_in (SETTLE_LD),
    .expired  (timer_expired)
  );

  // Only consumed in SAMPLE; dut_c never reaches an output without a register.
  always_comb begin
    mismatch = (bus.dut_c != nand_expected(vec));
    err_nxt  = err_q;
    if (mismatch && (err_q != ERR_MAX)) begin
      err_nxt = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      vec     <= '0;
      sweep   <= '0;
      dut_a_q <= 1'b0;
      dut_b_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ffv_q   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state   <= ST_DRIVE;
            vec     <= '0;
            sweep   <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            ffv_q   <= '0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_DRIVE: begin
          dut_a_q <= vec[1];
          dut_b_q <= vec[0];
          state   <= (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_WAIT;
        end
        ST_WAIT: begin
          if (timer_expired) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          err_q <= err_nxt;
          if (mismatch && !fv_q) begin
            fv_q  <= 1'b1;
            ffv_q <= vec;
          end
          vec   <= vec + 2'd1;
          state <= ST_DRIVE;
          if (vec == 2'd3) begin
            sweep <= sweep + SWEEP_W'(1);
            if (sweep == LAST_SWEEP) begin
              state   <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_nxt == '0);
              dut_a_q <= 1'b0;
              dut_b_q <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.dut_a          = dut_a_q;
  assign bus.dut_b          = dut_b_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_q;
  assign bus.fail_valid     = fv_q;
  assign bus.first_fail_vec = ffv_q;

endmodule

// File: tb/tb_demorgan_pattern_checker.sv
// Two checker instances (defaults, and SETTLE=0/PASSES=5) against a run-level reference model.
module tb_demorgan_pattern_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic c_now [2];

  always #5 clk = ~clk;

  demorgan_pattern_checker_if ifa ();
  demorgan_pattern_checker_if ifb ();

  assign ifa.start = start;
  assign ifb.start = start;
  assign ifa.dut_c = c_now[0];
  assign ifb.dut_c = c_now[1];

  demorgan_pattern_checker #(.SETTLE_CYCLES(2), .PASSES(1)) u_a (
    .clk (clk), .rst_n (rst_n), .bus (ifa.slave)
  );
  demorgan_pattern_checker #(.SETTLE_CYCLES(0), .PASSES(5)) u_b (
    .clk (clk), .rst_n (rst_n), .bus (ifb.slave)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: a run is a timeline of 4*P steps of S+2 cycles each.
  int S [2] = '{2, 0};
  int P [2] = '{1, 5};
  bit run [2];
  int k [2];
  int m_err [2];
  bit m_fv [2];
  int m_ffv [2];
  bit m_done [2];
  int mode [2];   // 0 NAND, 1 stuck-1, 2 stuck-0, 3 AND, 4 random

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic cval(input int md, input logic a, input logic b);
    case (md)
      0:       return ~(a & b);
      1:       return 1'b1;
      2:       return 1'b0;
      3:       return a & b;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic check_inst(input int i, input logic bz, input logic dn, input logic ps,
                            input logic a, input logic b, input logic [3:0] ec,
                            input logic fv, input logic [1:0] ff);
    int L;
    int v;
    L = S[i] + 2;
    v = (k[i] / L) % 4;
    chk($sformatf("busy%0d", i), 32'(bz), 32'(run[i]));
    chk($sformatf("done%0d", i), 32'(dn), 32'(m_done[i]));
    chk($sformatf("pass%0d", i), 32'(ps), 32'(m_done[i] && m_err[i] == 0));
    chk($sformatf("err_count%0d", i), 32'(ec), 32'(m_err[i]));
    chk($sformatf("fail_valid%0d", i), 32'(fv), 32'(m_fv[i]));
    chk($sformatf("first_fail_vec%0d", i), 32'(ff), 32'(m_ffv[i]));
    if (!run[i]) begin
      chk($sformatf("dut_a_idle%0d", i), 32'(a), 0);
      chk($sformatf("dut_b_idle%0d", i), 32'(b), 0);
    end else if (k[i] % L != 0) begin
      chk($sformatf("dut_a%0d", i), 32'(a), 32'((v >> 1) & 1));
      chk($sformatf("dut_b%0d", i), 32'(b), 32'(v & 1));
    end
  endtask

  task automatic model_step(input int i, input bit st);
    int L;
    int N;
    int v;
    L = S[i] + 2;
    N = 4 * P[i] * L;
    if (!rst_n) begin
      run[i] = 0; k[i] = 0; m_err[i] = 0; m_fv[i] = 0; m_ffv[i] = 0; m_done[i] = 0;
    end else if (!run[i]) begin
      if (st) begin
        run[i] = 1; k[i] = 0; m_err[i] = 0; m_fv[i] = 0; m_ffv[i] = 0; m_done[i] = 0;
      end
    end else begin
      if (k[i] % L == L - 1) begin
        v = (k[i] / L) % 4;
        if (c_now[i] != (v != 3)) begin
          if (m_err[i] < 15) m_err[i]++;
          if (!m_fv[i]) begin
            m_fv[i] = 1;
            m_ffv[i] = v;
          end
        end
      end
      k[i]++;
      if (k[i] == N) begin
        run[i] = 0;
        m_done[i] = 1;
      end
    end
  endtask

  // Compare, then drive the inputs the next rising edge will see, then advance the model.
  task automatic tick(input bit st, input bit rs);
    @(negedge clk);
    check_inst(0, ifa.busy, ifa.done, ifa.pass, ifa.dut_a, ifa.dut_b,
               ifa.err_count, ifa.fail_valid, ifa.first_fail_vec);
    check_inst(1, ifb.busy, ifb.done, ifb.pass, ifb.dut_a, ifb.dut_b,
               ifb.err_count, ifb.fail_valid, ifb.first_fail_vec);
    rst_n = rs;
    start = st;
    c_now[0] = cval(mode[0], ifa.dut_a, ifa.dut_b);
    c_now[1] = cval(mode[1], ifb.dut_a, ifb.dut_b);
    model_step(0, st);
    model_step(1, st);
  endtask

  task automatic run_until_done(output int ea, output int eb);
    int e;
    e = 0; ea = -1; eb = -1;
    while (e < 400 && (ea < 0 || eb < 0)) begin
      tick(0, 1);
      if (ifa.done && ea < 0) ea = e;
      if (ifb.done && eb < 0) eb = e;
      e++;
    end
    chk("run_timeout", 32'(ea >= 0 && eb >= 0), 1);
  endtask

  initial begin
    int ea;
    int eb;
    mode[0] = 0; mode[1] = 0;
    c_now[0] = 1'b0; c_now[1] = 1'b0;
    for (int i = 0; i < 2; i++) model_step(i, 0);

    repeat (3) tick(0, 0);
    chk("reset_busy", 32'(ifa.busy), 0);
    chk("reset_err", 32'(ifb.err_count), 0);

    // Release reset and request a run on the same edge: correct NAND / stuck-at-1.
    mode[0] = 0; mode[1] = 1;
    tick(1, 1);
    run_until_done(ea, eb);
    chk("nand_done_edge", 32'(ea), 16);
    chk("stuck1_done_edge", 32'(eb), 40);
    chk("nand_pass", 32'(ifa.pass), 1);
    chk("nand_err", 32'(ifa.err_count), 0);
    chk("nand_fv", 32'(ifa.fail_valid), 0);
    chk("stuck1_err", 32'(ifb.err_count), 5);
    chk("stuck1_ffv", 32'(ifb.first_fail_vec), 3);
    chk("stuck1_pass", 32'(ifb.pass), 0);

    // Stuck-at-1 on one vector / AND stage mismatching all 20 samples -> saturate.
    mode[0] = 1; mode[1] = 3;
    tick(1, 1);
    run_until_done(ea, eb);
    chk("stuck1a_err", 32'(ifa.err_count), 1);
    chk("stuck1a_ffv", 32'(ifa.first_fail_vec), 3);
    chk("stuck1a_fv", 32'(ifa.fail_valid), 1);
    chk("stuck1a_pass", 32'(ifa.pass), 0);
    chk("and_err_sat", 32'(ifb.err_count), 15);
    chk("and_ffv", 32'(ifb.first_fail_vec), 0);
    chk("and_done_edge", 32'(eb), 40);

    // Reset during WAIT of vector 2 on instance a, checked before any clock edge.
    mode[0] = 2; mode[1] = 2;
    tick(1, 1);
    repeat (9) tick(0, 1);
    chk("pre_rst_busy", 32'(ifa.busy), 1);
    tick(0, 0);
    #1;
    chk("async_rst_busy", 32'(ifa.busy), 0);
    chk("async_rst_a", 32'(ifa.dut_a), 0);
    chk("async_rst_err", 32'(ifa.err_count), 0);
    chk("async_rst_fv", 32'(ifb.fail_valid), 0);
    tick(0, 0);
    mode[0] = 0; mode[1] = 0;
    tick(1, 1);
    run_until_done(ea, eb);
    chk("post_rst_pass", 32'(ifa.pass), 1);
    chk("post_rst_pass_b", 32'(ifb.pass), 1);

    // start held high: re-accepted on the first DONE cycle.
    mode[0] = 4; mode[1] = 4;
    repeat (150) tick(1, 1);

    // Randomized start pulses, stage behaviour and occasional resets.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        mode[0] = int'($urandom_range(0, 4));
        mode[1] = int'($urandom_range(0, 4));
      end
      tick(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 299) != 0));
    end
    tick(0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
